// File: rtl/wb_decoder_pkg.sv
// Shared definitions for the Caravel user-area Wishbone decoder.
// Holds slot indices, the user-area base, error response words,
// the FSM state encoding and the address-validity helper.
package wb_decoder_pkg;

  localparam logic [7:0] GPIO_SLOT      = 8'd0;
  localparam logic [7:0] LA_SLOT        = 8'd1;
  localparam logic [7:0] TEAM_SLOT_BASE = 8'd2;

  localparam logic [7:0] USER_BASE = 8'h30;

  localparam logic [31:0] ERR_DECODE_WORD  = 32'hBADD_ADD0;
  localparam logic [31:0] ERR_TIMEOUT_WORD = 32'hDEAD_BEEF;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

  // Request targets the user area and a slot that actually exists.
  function automatic logic addr_valid(input logic [7:0] region,
                                      input logic [7:0] slot,
                                      input int unsigned num_slaves);
    return (region == USER_BASE) && (32'(slot) < num_slaves);
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Slave-ack watchdog for the Wishbone decoder.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   clear      : restart counting (entry into WAIT)
//   run        : decoder is waiting on a slave
//   expired_c  : combinational; high in the LIMIT-th consecutive WAIT cycle
module wb_timeout_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired_c
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] cnt_q;

  // Counts completed WAIT cycles; parks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (run && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_c = run && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/wishbone_decoder.sv
// Caravel user-area Wishbone decoder: routes one master transaction to
// gpio_control_wrapper (slot 0), la_control_wrapper (slot 1) or a team
// wrapper (slots 2..NUM_TEAMS+1) selected by wbs_adr_i[23:16].
// Optional slave timeout is compiled in with WB_DECODER_TIMEOUT_EN.
// Ports:
//   wb_clk_i, wb_rst_i          : clock, synchronous active-high reset
//   wbs_stb/cyc/we/sel/dat/adr_i: master request
//   wbs_ack_o, wbs_dat_o        : master response (registered)
//   slv_stb_o                   : one-hot slave strobe (registered)
//   slv_ack_i, slv_dat_i        : per-slave ack and flattened read data
//   err_cnt_o                   : saturating error-response count
module wishbone_decoder
  import wb_decoder_pkg::*;
#(
  parameter int unsigned NUM_TEAMS      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic                            wbs_stb_i,
  input  logic                            wbs_cyc_i,
  input  logic                            wbs_we_i,
  input  logic [3:0]                      wbs_sel_i,
  input  logic [31:0]                     wbs_dat_i,
  input  logic [31:0]                     wbs_adr_i,
  output logic                            wbs_ack_o,
  output logic [31:0]                     wbs_dat_o,
  output logic [NUM_TEAMS+1:0]            slv_stb_o,
  input  logic [NUM_TEAMS+1:0]            slv_ack_i,
  input  logic [32*(NUM_TEAMS+2)-1:0]     slv_dat_i,
  output logic [7:0]                      err_cnt_o
);

  localparam int unsigned NUM_SLAVES = NUM_TEAMS + 32'(TEAM_SLOT_BASE);
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ERR_W      = 8;

  logic [STATE_W-1:0]    state_q, state_d;
  logic [NUM_SLAVES-1:0] stb_q, stb_d;
  logic                  ack_q, ack_d;
  logic [DATA_W-1:0]     dat_q, dat_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic                  we_q, we_d;

  logic              req_c;
  logic              req_valid_c;
  logic              sel_ack_c;
  logic [DATA_W-1:0] sel_dat_c;
  logic              start_wait_c;
  logic              err_inc_c;
  logic              timeout_c;
  logic              unused_c;

  assign req_c       = wbs_stb_i && wbs_cyc_i;
  assign req_valid_c = addr_valid(wbs_adr_i[31:24], wbs_adr_i[23:16], NUM_SLAVES);

  // The registered one-hot strobe doubles as the latched slot, so masking
  // acks with it discards every non-selected slave's ack.
  assign sel_ack_c = |(slv_ack_i & stb_q);

  always_comb begin
    sel_dat_c = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (stb_q[k]) begin
        sel_dat_c = sel_dat_c | slv_dat_i[DATA_W*k +: DATA_W];
      end
    end
  end

`ifdef WB_DECODER_TIMEOUT_EN
  wb_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .clear     (start_wait_c),
    .run       (state_q == ST_WAIT),
    .expired_c (timeout_c)
  );
  assign unused_c = &{1'b0, wbs_sel_i, wbs_dat_i, wbs_adr_i[15:0]};
`else
  assign timeout_c = 1'b0;
  assign unused_c  = &{1'b0, wbs_sel_i, wbs_dat_i, wbs_adr_i[15:0],
                       timeout_c, 8'(TIMEOUT_CYCLES)};
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    stb_d        = stb_q;
    ack_d        = 1'b0;
    dat_d        = dat_q;
    err_d        = err_q;
    we_d         = we_q;
    start_wait_c = 1'b0;
    err_inc_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stb_d = '0;
        if (req_c) begin
          we_d = wbs_we_i;
          if (req_valid_c) begin
            state_d      = ST_WAIT;
            stb_d        = NUM_SLAVES'(1) << wbs_adr_i[23:16];
            start_wait_c = 1'b1;
          end else begin
            state_d   = ST_RESP;
            ack_d     = 1'b1;
            dat_d     = ERR_DECODE_WORD;
            err_inc_c = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        // Abort outranks a same-cycle ack, which outranks a timeout.
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
          stb_d   = '0;
        end else if (sel_ack_c) begin
          state_d = ST_RESP;
          stb_d   = '0;
          ack_d   = 1'b1;
          dat_d   = we_q ? '0 : sel_dat_c;
        end else if (timeout_c) begin
          state_d   = ST_RESP;
          stb_d     = '0;
          ack_d     = 1'b1;
          dat_d     = ERR_TIMEOUT_WORD;
          err_inc_c = 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        stb_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        stb_d   = '0;
      end
    endcase

    if (err_inc_c && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  // State and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      stb_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      err_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
      we_q    <= we_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign slv_stb_o = stb_q;
  assign err_cnt_o = err_q;

endmodule

// File: tb/tb_wishbone_decoder.sv
// Randomized self-checking bench for wishbone_decoder (NUM_TEAMS=1).
// Each transaction's outcome is predicted from its timeline: the first of
// abort, target ack or timeout ends WAIT, and the response follows a cycle
// later. Timeout scenarios run when WB_DECODER_TIMEOUT_EN is defined.
module tb_wishbone_decoder;

  localparam int unsigned NUM_TEAMS = 1;
  localparam int unsigned NSL       = NUM_TEAMS + 2;
  localparam int unsigned TMO       = 4;
  localparam int          NEVER     = 1000;
`ifdef WB_DECODER_TIMEOUT_EN
  localparam int          TMO_LIM   = TMO;
`else
  localparam int          TMO_LIM   = NEVER;
`endif

  logic              clk;
  logic              wb_rst_i;
  logic              wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_dat_i, wbs_adr_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [NSL-1:0]    slv_stb_o;
  logic [NSL-1:0]    slv_ack_i;
  logic [32*NSL-1:0] slv_dat_i;
  logic [7:0]        err_cnt_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_dat;
  logic [7:0]  exp_err;

  wishbone_decoder #(
    .NUM_TEAMS      (NUM_TEAMS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (wb_rst_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .slv_stb_o (slv_stb_o),
    .slv_ack_i (slv_ack_i),
    .slv_dat_i (slv_dat_i),
    .err_cnt_o (err_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic exp_ack, input logic [NSL-1:0] exp_stb);
    check({tag, ".ack"}, 32'(wbs_ack_o), 32'(exp_ack));
    check({tag, ".stb"}, 32'(slv_stb_o), 32'(exp_stb));
    check({tag, ".dat"}, wbs_dat_o, exp_dat);
    check({tag, ".err"}, 32'(err_cnt_o), 32'(exp_err));
  endtask

  task automatic randomize_slave_data();
    for (int j = 0; j < int'(NSL); j++) slv_dat_i[32*j +: 32] = $urandom;
  endtask

  // One master transaction. k: cycle the target slave acks (0 = never),
  // a: cycle cyc drops (0 = never), force0: slave 0 acks every cycle.
  task automatic run_txn(input string tag, input logic [31:0] adr, input logic we,
                         input int k, input int a, input logic force0);
    logic           valid;
    int             s, kk, aa, ev, last, kind;
    logic [NSL-1:0] tgt, noise, exp_stb;
    logic [31:0]    dat_k;
    logic           exp_ack;

    valid = (adr[31:24] == 8'h30) && (int'(adr[23:16]) < int'(NSL));
    s     = int'(adr[23:16]);
    tgt   = valid ? (NSL'(1) << s) : '0;
    kk    = (k > 0) ? k : NEVER;
    aa    = (a > 0) ? a : NEVER;
    ev    = aa;
    if (kk < ev) ev = kk;
    if (TMO_LIM < ev) ev = TMO_LIM;
    kind  = (aa == ev) ? 0 : ((kk == ev) ? 1 : 2);  // 0 abort, 1 ack, 2 timeout
    last  = valid ? ev + 1 : 1;
    dat_k = '0;

    // Cycle 0: bus idle, request presented.
    @(negedge clk);
    check_outputs({tag, ".c0"}, 1'b0, '0);
    wbs_adr_i = adr;
    wbs_we_i  = we;
    wbs_sel_i = 4'($urandom);
    wbs_dat_i = $urandom;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    randomize_slave_data();
    slv_ack_i = NSL'($urandom) & ~tgt;

    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      exp_stb = (valid && c <= ev) ? tgt : '0;
      exp_ack = 1'b0;
      if (c == last && (!valid || kind != 0)) begin
        exp_ack = 1'b1;
        if (!valid)         exp_dat = 32'hBADD_ADD0;
        else if (kind == 2) exp_dat = 32'hDEAD_BEEF;
        else                exp_dat = we ? 32'h0 : dat_k;
        if ((!valid || kind == 2) && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      end
      check_outputs({tag, $sformatf(".c%0d", c)}, exp_ack, exp_stb);

      randomize_slave_data();
      noise = NSL'($urandom) & ~tgt;
      if (force0 && !tgt[0]) noise[0] = 1'b1;
      if (valid && c == kk) begin
        noise = noise | tgt;
        dat_k = slv_dat_i[32*s +: 32];
      end
      slv_ack_i = noise;
      if ((valid && c >= aa) || c == last) begin
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
      end
    end
  endtask

  initial begin
    wb_rst_i  = 1'b1;
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = '0;
    wbs_dat_i = '0;
    wbs_adr_i = '0;
    slv_ack_i = '0;
    slv_dat_i = '0;
    exp_dat   = '0;
    exp_err   = '0;

    @(negedge clk);
    @(negedge clk);
    check_outputs("reset", 1'b0, '0);
    wb_rst_i = 1'b0;

    // Slot 1 read; strobe in cycle 1, slave acks 3 cycles later.
    run_txn("la_read", 32'h3001_0004, 1'b0, 4, 0, 1'b0);
    // Out-of-range slot write: immediate decode error.
    run_txn("bad_slot", 32'h3005_0000, 1'b1, 0, 0, 1'b0);
    // Wrong region.
    run_txn("bad_region", 32'h2000_0000, 1'b0, 0, 0, 1'b0);
    // Write to a valid slot returns zero data.
    run_txn("team_write", 32'h3002_0010, 1'b1, 2, 0, 1'b0);
    // Abort and target ack in the same cycle: abort wins.
    run_txn("abort_ack", 32'h3002_0000, 1'b0, 2, 2, 1'b0);
    // Slave 0 keeps acking while slot 2 is selected.
    run_txn("stray_ack", 32'h3002_0008, 1'b0, 3, 0, 1'b1);
    // Single-cycle wait.
    run_txn("fast_gpio", 32'h3000_0000, 1'b0, 1, 0, 1'b0);
`ifdef WB_DECODER_TIMEOUT_EN
    // Slot 0 never acks.
    run_txn("timeout", 32'h3000_0000, 1'b0, 0, 0, 1'b0);
`endif

    for (int n = 0; n < 150; n++) begin
      logic [31:0] adr;
      adr[31:24] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h30;
      adr[23:16] = 8'($urandom_range(0, 5));
      adr[15:0]  = 16'($urandom);
      run_txn($sformatf("rnd%0d", n), adr, 1'($urandom), $urandom_range(1, 8),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0, 1'($urandom));
    end

    // Drive the error counter into saturation.
    for (int n = 0; n < 300; n++) begin
      run_txn("sat", 32'h3007_0000, 1'b0, 0, 0, 1'b0);
    end
    check("sat_value", 32'(err_cnt_o), 32'h0000_00FF);

    // Reset in the middle of WAIT abandons the transaction.
    @(negedge clk);
    wbs_adr_i = 32'h3000_0000;
    wbs_we_i  = 1'b0;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    slv_ack_i = '0;
    @(negedge clk);
    check_outputs("rst_wait.c1", 1'b0, NSL'(1));
    wb_rst_i = 1'b1;
    @(negedge clk);
    exp_dat = '0;
    exp_err = '0;
    check_outputs("rst_wait.c2", 1'b0, '0);
    wb_rst_i  = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    @(negedge clk);
    check_outputs("rst_wait.c3", 1'b0, '0);

    run_txn("post_rst", 32'h3001_0000, 1'b0, 2, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
